// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-slot alarm scheduler: FSM state
// encoding, the BCD hh:mm record, write validation and counter sizing.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RINGING  = 2'd1,
        ST_SNOOZING = 2'd2
    } alarm_state_e;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_hhmm_t;

    // Bits needed for a counter that reaches max_val (at least one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Legal 00:00..23:59 with every BCD digit in range.
    function automatic logic bcd_hhmm_valid(input bcd_hhmm_t t);
        return (t.h0 <= 4'd9) && (t.m1 <= 4'd5) && (t.m0 <= 4'd9) &&
               ((t.h1 < 2'd2) || ((t.h1 == 2'd2) && (t.h0 <= 4'd3)));
    endfunction

    localparam int RING_CNT_W_MAX = 8;
    localparam int SNZ_CNT_W_MAX  = 10;
    localparam int SNZ_USED_W_MAX = 3;

endpackage

// File: rtl/alarm_slot_bank.sv
// Alarm slot storage with write validation and per-slot time comparators.
// match_vec is combinational from the stored slots, so it sees pre-write contents.
module alarm_slot_bank
    import alarm_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                 clk_1s,
    input  logic                 reset,
    input  logic                 al_on,
    input  bcd_hhmm_t            cur_hm,
    input  logic [3:0]           cur_s1,
    input  logic [3:0]           cur_s0,
    input  logic                 wr_en,
    input  logic [SLOT_W-1:0]    wr_slot,
    input  bcd_hhmm_t            wr_hm,
    input  logic                 wr_arm,
    output logic [NUM_SLOTS-1:0] match_vec,
    output logic                 wr_accept,
    output logic                 wr_err
);

    bcd_hhmm_t            slot_hm [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] armed;

    assign wr_accept = wr_en && bcd_hhmm_valid(wr_hm) && (32'(wr_slot) < NUM_SLOTS);

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_hm[i] <= '0;
            armed  <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_accept;
            if (wr_accept) begin
                slot_hm[wr_slot] <= wr_hm;
                armed[wr_slot]   <= wr_arm;
            end
        end
    end

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            match_vec[i] = armed[i] && al_on && (slot_hm[i] == cur_hm) &&
                           (cur_s1 == 4'd0) && (cur_s0 == 4'd0);
        end
    end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler: ring/snooze/timeout FSM, pending mask and slot priority.
// Define ALARM_SNOOZE_EN to build the snooze path; otherwise snooze is ignored.
module alarm_scheduler
    import alarm_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_MAX     = 3
) (
    input  logic                         clk_1s,
    input  logic                         reset,
    input  logic [1:0]                   cur_h1,
    input  logic [3:0]                   cur_h0,
    input  logic [3:0]                   cur_m1,
    input  logic [3:0]                   cur_m0,
    input  logic [3:0]                   cur_s1,
    input  logic [3:0]                   cur_s0,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_SLOTS)-1:0] wr_slot,
    input  logic [1:0]                   wr_h1,
    input  logic [3:0]                   wr_h0,
    input  logic [3:0]                   wr_m1,
    input  logic [3:0]                   wr_m0,
    input  logic                         wr_arm,
    input  logic                         al_on,
    input  logic                         stop,
    input  logic                         snooze,
    output logic                         alarm,
    output logic [$clog2(NUM_SLOTS)-1:0] active_slot,
    output logic [1:0]                   state,
    output logic                         wr_err
);

    localparam int SLOT_W     = $clog2(NUM_SLOTS);
    localparam int RING_CNT_W = cnt_w(RING_TIMEOUT_S - 1);
    localparam logic [RING_CNT_W-1:0] RING_LAST = RING_CNT_W'(RING_TIMEOUT_S - 1);

`ifdef ALARM_SNOOZE_EN
    localparam int SNZ_CNT_W  = cnt_w(SNOOZE_MIN * 60 - 1);
    localparam int SNZ_USED_W = cnt_w(SNOOZE_MAX);
    localparam logic [SNZ_CNT_W-1:0]  SNZ_LOAD = SNZ_CNT_W'(SNOOZE_MIN * 60 - 1);
    localparam logic [SNZ_USED_W-1:0] SNZ_LIM  = SNZ_USED_W'(SNOOZE_MAX);
    logic [SNZ_CNT_W-1:0]  snz_cnt;
    logic [SNZ_USED_W-1:0] snooze_used;
`else
    localparam int cfg_unused = SNOOZE_MIN + SNOOZE_MAX;
    logic snooze_unused;
    assign snooze_unused = snooze;
`endif

    alarm_state_e          st;
    logic [NUM_SLOTS-1:0]  match_vec, pend, pend_nxt;
    logic [RING_CNT_W-1:0] ring_cnt;
    logic [SLOT_W-1:0]     win;
    logic                  start, wr_accept;
    bcd_hhmm_t             cur_hm, wr_hm;

    assign cur_hm = {cur_h1, cur_h0, cur_m1, cur_m0};
    assign wr_hm  = {wr_h1, wr_h0, wr_m1, wr_m0};
    assign state  = st;

    alarm_slot_bank #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) u_bank (
        .clk_1s    (clk_1s),
        .reset     (reset),
        .al_on     (al_on),
        .cur_hm    (cur_hm),
        .cur_s1    (cur_s1),
        .cur_s0    (cur_s0),
        .wr_en     (wr_en),
        .wr_slot   (wr_slot),
        .wr_hm     (wr_hm),
        .wr_arm    (wr_arm),
        .match_vec (match_vec),
        .wr_accept (wr_accept),
        .wr_err    (wr_err)
    );

    function automatic logic [SLOT_W-1:0] lowest(input logic [NUM_SLOTS-1:0] v);
        lowest = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) if (v[i]) lowest = SLOT_W'(i);
    endfunction

    // Pending slots outrank fresh matches; the winner never lands in the mask.
    always_comb begin
        win      = (|pend) ? lowest(pend) : lowest(match_vec);
        start    = (st == ST_IDLE) && ((|pend) || (|match_vec));
        pend_nxt = pend | match_vec;
        if (start)     pend_nxt[win]     = 1'b0;
        if (wr_accept) pend_nxt[wr_slot] = 1'b0;
    end

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            st          <= ST_IDLE;
            alarm       <= 1'b0;
            active_slot <= '0;
            pend        <= '0;
            ring_cnt    <= '0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt     <= '0;
            snooze_used <= '0;
`endif
        end else if (!al_on) begin
            st    <= ST_IDLE;
            alarm <= 1'b0;
            pend  <= '0;
        end else begin
            pend <= pend_nxt;
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        st          <= ST_RINGING;
                        alarm       <= 1'b1;
                        active_slot <= win;
                        ring_cnt    <= '0;
`ifdef ALARM_SNOOZE_EN
                        snooze_used <= '0;
`endif
                    end
                end
                ST_RINGING: begin
                    if (stop) begin
                        st    <= ST_IDLE;
                        alarm <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze && (snooze_used < SNZ_LIM)) begin
                        st      <= ST_SNOOZING;
                        alarm   <= 1'b0;
                        snz_cnt <= SNZ_LOAD;
`endif
                    end else if (ring_cnt == RING_LAST) begin
                        st    <= ST_IDLE;
                        alarm <= 1'b0;
                    end else begin
                        ring_cnt <= ring_cnt + RING_CNT_W'(1);
                    end
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZING: begin
                    if (stop) begin
                        st <= ST_IDLE;
                    end else if (snz_cnt == '0) begin
                        st          <= ST_RINGING;
                        alarm       <= 1'b1;
                        ring_cnt    <= '0;
                        snooze_used <= snooze_used + SNZ_USED_W'(1);
                    end else begin
                        snz_cnt <= snz_cnt - SNZ_CNT_W'(1);
                    end
                end
`endif
                default: begin
                    st    <= ST_IDLE;
                    alarm <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler: a running BCD clock model, scripted writes and
// button presses, and a scoreboard of expected {wr_err, alarm, state, active_slot}.
module tb_alarm_scheduler;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RING = 2'd1;
    localparam logic [1:0] SNZ  = 2'd2;

    logic       clk_1s = 1'b0;
    logic       reset;
    logic [1:0] cur_h1;
    logic [3:0] cur_h0, cur_m1, cur_m0, cur_s1, cur_s0;
    logic       wr_en;
    logic [1:0] wr_slot;
    logic [1:0] wr_h1;
    logic [3:0] wr_h0, wr_m1, wr_m0;
    logic       wr_arm, al_on, stop, snooze;
    logic       alarm, wr_err;
    logic [1:0] active_slot, state;

    alarm_scheduler #(
        .NUM_SLOTS(4), .SNOOZE_MIN(5), .RING_TIMEOUT_S(60), .SNOOZE_MAX(3)
    ) dut (
        .clk_1s(clk_1s), .reset(reset),
        .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
        .cur_s1(cur_s1), .cur_s0(cur_s0),
        .wr_en(wr_en), .wr_slot(wr_slot),
        .wr_h1(wr_h1), .wr_h0(wr_h0), .wr_m1(wr_m1), .wr_m0(wr_m0),
        .wr_arm(wr_arm), .al_on(al_on), .stop(stop), .snooze(snooze),
        .alarm(alarm), .active_slot(active_slot), .state(state), .wr_err(wr_err)
    );

    always #5 clk_1s = ~clk_1s;

    typedef struct {
        string      tag;
        logic [5:0] v;
    } exp_t;

    exp_t       sb[$];
    int         hh, mm, ss;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] act;

    function automatic logic [5:0] ev(input logic w, input logic a,
                                      input logic [1:0] st, input logic [1:0] sl);
        return {w, a, st, sl};
    endfunction

    task automatic drive_time();
        cur_h1 = 2'(hh / 10);
        cur_h0 = 4'(hh % 10);
        cur_m1 = 4'(mm / 10);
        cur_m0 = 4'(mm % 10);
        cur_s1 = 4'(ss / 10);
        cur_s0 = 4'(ss % 10);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hh = h; mm = m; ss = s;
        drive_time();
    endtask

    // One clock edge; the time model then advances one second.
    task automatic step();
        @(posedge clk_1s);
        #1;
        ss++;
        if (ss == 60) begin
            ss = 0; mm++;
            if (mm == 60) begin
                mm = 0; hh++;
                if (hh == 24) hh = 0;
            end
        end
        drive_time();
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic expect_out(input string tag, input logic [5:0] v);
        sb.push_back('{tag: tag, v: v});
    endtask

    task automatic check_out();
        exp_t       e;
        logic [5:0] obs;
        obs = {wr_err, alarm, state, active_slot};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %b required nothing queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s: observed %b required %b ({wr_err,alarm,state,slot})",
                       e.tag, obs, e.v);
            end
        end
    endtask

    task automatic sc(input string tag, input logic [5:0] v);
        expect_out(tag, v);
        step();
        check_out();
    endtask

    task automatic wr(input logic [1:0] slot, input logic [1:0] h1, input logic [3:0] h0,
                      input logic [3:0] m1, input logic [3:0] m0, input logic arm,
                      input logic err, input string tag);
        wr_en = 1'b1; wr_slot = slot; wr_arm = arm;
        wr_h1 = h1; wr_h0 = h0; wr_m1 = m1; wr_m0 = m0;
        sc(tag, ev(err, 1'b0, IDLE, act));
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; al_on = 1'b0; stop = 1'b0; snooze = 1'b0;
        wr_en = 1'b0; wr_slot = '0; wr_arm = 1'b0;
        wr_h1 = '0; wr_h0 = '0; wr_m1 = '0; wr_m0 = '0;
        act = 2'd0;
        set_time(7, 29, 48);
        repeat (2) @(posedge clk_1s);
        #1;
        expect_out("reset_values", ev(0, 0, IDLE, 0));
        check_out();
        reset = 1'b0;
        al_on = 1'b1;

        // Single alarm, match latency and auto-timeout
        set_time(7, 29, 50);
        wr(2'd0, 2'd0, 4'd7, 4'd3, 4'd0, 1'b1, 1'b0, "wr_slot0_0730");
        cyc(8);
        sc("idle_at_072959", ev(0, 0, IDLE, 0));
        sc("match_073000", ev(0, 1, RING, 0));
        cyc(58);
        sc("ring_last_cycle", ev(0, 1, RING, 0));
        sc("auto_timeout", ev(0, 0, IDLE, 0));

        // Simultaneous slots: lowest wins, the other rings after one IDLE cycle
        wr(2'd1, 2'd0, 4'd8, 4'd0, 4'd0, 1'b1, 1'b0, "wr_slot1_0800");
        wr(2'd2, 2'd0, 4'd8, 4'd0, 4'd0, 1'b1, 1'b0, "wr_slot2_0800");
        set_time(8, 0, 0);
        sc("simul_lowest_wins", ev(0, 1, RING, 1));
        act = 2'd1;
        cyc(3);
        stop = 1'b1;
        sc("stop_slot1", ev(0, 0, IDLE, 1));
        stop = 1'b0;
        sc("pending_slot2_rings", ev(0, 1, RING, 2));
        act = 2'd2;
        stop = 1'b1;
        sc("stop_slot2", ev(0, 0, IDLE, 2));
        stop = 1'b0;
        sc("nothing_pending", ev(0, 0, IDLE, 2));

        // Snooze sequencing and snooze limit
        wr(2'd3, 2'd0, 4'd9, 4'd0, 4'd0, 1'b1, 1'b0, "wr_slot3_0900");
        set_time(9, 0, 0);
        sc("ring_slot3", ev(0, 1, RING, 3));
        act = 2'd3;
`ifdef ALARM_SNOOZE_EN
        cyc(2);
        for (int k = 0; k < 3; k++) begin
            snooze = 1'b1;
            sc("snooze_enter", ev(0, 0, SNZ, 3));
            snooze = 1'b0;
            cyc(298);
            sc("snooze_last_low", ev(0, 0, SNZ, 3));
            sc("snooze_rering", ev(0, 1, RING, 3));
        end
        snooze = 1'b1;
        sc("snooze_limit_ignored", ev(0, 1, RING, 3));
        snooze = 1'b0;
        cyc(57);
        sc("post_limit_last_ring", ev(0, 1, RING, 3));
        sc("post_limit_timeout", ev(0, 0, IDLE, 3));
`else
        snooze = 1'b1;
        sc("snooze_disabled_ignored", ev(0, 1, RING, 3));
        snooze = 1'b0;
        stop = 1'b1;
        sc("stop_slot3", ev(0, 0, IDLE, 3));
        stop = 1'b0;
`endif

        // stop and snooze on the same edge
        set_time(9, 0, 0);
        sc("ring_slot3_again", ev(0, 1, RING, 3));
        stop = 1'b1; snooze = 1'b1;
        sc("stop_beats_snooze", ev(0, 0, IDLE, 3));
        stop = 1'b0; snooze = 1'b0;
        sc("stays_idle", ev(0, 0, IDLE, 3));

        // Write validation
        wr(2'd0, 2'd2, 4'd4, 4'd0, 4'd0, 1'b1, 1'b1, "wr_reject_24h");
        sc("wr_err_one_cycle", ev(0, 0, IDLE, 3));
        wr(2'd0, 2'd1, 4'd10, 4'd0, 4'd0, 1'b0, 1'b1, "wr_reject_bad_digit");
        wr(2'd0, 2'd1, 4'd2, 4'd6, 4'd0, 1'b0, 1'b1, "wr_reject_min60");
        set_time(7, 30, 0);
        sc("slot0_unchanged", ev(0, 1, RING, 0));
        act = 2'd0;
        stop = 1'b1;
        sc("stop_slot0", ev(0, 0, IDLE, 0));
        stop = 1'b0;
        wr(2'd3, 2'd2, 4'd3, 4'd5, 4'd9, 1'b1, 1'b0, "wr_slot3_2359");
        set_time(23, 58, 59);
        sc("idle_at_235859", ev(0, 0, IDLE, 0));
        sc("match_235900", ev(0, 1, RING, 3));
        act = 2'd3;
        stop = 1'b1;
        sc("stop_2359", ev(0, 0, IDLE, 3));
        stop = 1'b0;

        // al_on drop clears the pending slot
        wr(2'd1, 2'd1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "wr_slot1_1000");
        wr(2'd2, 2'd1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "wr_slot2_1000");
        set_time(10, 0, 0);
        sc("ring_slot1_1000", ev(0, 1, RING, 1));
        act = 2'd1;
`ifdef ALARM_SNOOZE_EN
        snooze = 1'b1;
        sc("snooze_with_pending", ev(0, 0, SNZ, 1));
        snooze = 1'b0;
`endif
        al_on = 1'b0;
        sc("al_off_to_idle", ev(0, 0, IDLE, 1));
        al_on = 1'b1;
        sc("pending_dropped", ev(0, 0, IDLE, 1));
        cyc(5);
        sc("still_no_ring", ev(0, 0, IDLE, 1));

        // Asynchronous reset in the middle of ringing
        set_time(10, 0, 0);
        sc("ring_before_reset", ev(0, 1, RING, 1));
        cyc(2);
        #3 reset = 1'b1;
        #1;
        expect_out("async_reset_now", ev(0, 0, IDLE, 0));
        check_out();
        #1 reset = 1'b0;
        set_time(10, 0, 0);
        sc("slots_cleared_by_reset", ev(0, 0, IDLE, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
